dmem_ws: RTL and testbench

- Byte-addressable RV32 data memory with a req/ready/done handshake and a parametrised wait-state latency.
- Successor of the single-cycle data memory. Adds:
  - LB/LH/LW/LBU/LHU/SB/SH/SW with sign/zero extension and byte/halfword write enables;
  - misalignment detection;
  - configurable depth;
  - multi-cycle access, so the non-pipelined core can stall on slow memory.
- Sits between the core's MEM stage control and the data array.

---
 rtl/dmem_ws.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_ws.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ws.sv
// Byte-addressable RV32 data memory with a req/ready/done handshake and a fixed
// number of wait states between request accept and the one-cycle done pulse.
package controls_pkg;
    typedef enum logic [3:0] {
        MemNone = 4'd0,
        MemLb   = 4'd1,
        MemLh   = 4'd2,
        MemLw   = 4'd3,
        MemLbu  = 4'd4,
        MemLhu  = 4'd5,
        MemSb   = 4'd6,
        MemSh   = 4'd7,
        MemSw   = 4'd8
    } mem_op;
endpackage

module dmem_ws
    import controls_pkg::*;
#(
    parameter int unsigned Addr_bits   = 32,
    parameter int unsigned Word_size   = 32,
    parameter int unsigned Depth_words = 256,
    parameter int unsigned Latency     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  mem_op                rd_wr,
    input  logic [Addr_bits-1:0] addr,
    input  logic [Word_size-1:0] din,
    output logic                 ready,
    output logic                 done,
    output logic [Word_size-1:0] dout,
    output logic                 misaligned
);
    localparam int unsigned IdxBits = $clog2(Depth_words);

    if (Word_size != 32) begin : g_bad_word_size
        $error("dmem_ws: Word_size must be 32");
    end
    if (Depth_words < 4 || (Depth_words & (Depth_words - 1)) != 0) begin : g_bad_depth
        $error("dmem_ws: Depth_words must be a power of two and at least 4");
    end
    if (Latency < 1 || Latency > 15) begin : g_bad_latency
        $error("dmem_ws: Latency must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    function automatic logic is_access(mem_op op);
        return op inside {MemLb, MemLh, MemLw, MemLbu, MemLhu, MemSb, MemSh, MemSw};
    endfunction

    function automatic logic is_store(mem_op op);
        return op inside {MemSb, MemSh, MemSw};
    endfunction

    function automatic logic is_misaligned(mem_op op, logic [1:0] a);
        case (op)
            MemLh, MemLhu, MemSh: return a[0];
            MemLw, MemSw:         return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    mem_op                op_q, op_d;
    logic [IdxBits+1:0]   addr_q, addr_d;
    logic [Word_size-1:0] din_q, din_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic [Word_size-1:0] dout_q, dout_d;
    logic                 mis_q, mis_d;

    logic [31:0]          mem_q [Depth_words];

    logic [IdxBits-1:0]   idx;
    logic [1:0]           lane;
    logic [31:0]          rdata;
    logic [7:0]           rbyte;
    logic [15:0]          rhalf;
    logic [31:0]          load_val;
    logic [31:0]          wdata;
    logic [3:0]           be;
    logic [3:0]           we;
    logic                 cur_mis;
    logic                 commit;
    logic                 unused_addr_hi;

    assign unused_addr_hi = ^addr[Addr_bits-1:IdxBits+2];

    assign idx     = addr_q[IdxBits+1:2];
    assign lane    = addr_q[1:0];
    assign rdata   = mem_q[idx];
    assign cur_mis = is_misaligned(op_q, lane);
    // The edge that leaves WAIT is the one that enters RESP: read, write and done all land here.
    assign commit  = (state_q == StWait) && (cnt_q == 4'd1) && !rst;

    always_comb begin
        rbyte    = rdata[{lane, 3'b000} +: 8];
        rhalf    = lane[1] ? rdata[31:16] : rdata[15:0];
        load_val = '0;
        case (op_q)
            MemLb:   load_val = {{24{rbyte[7]}}, rbyte};
            MemLbu:  load_val = {24'b0, rbyte};
            MemLh:   load_val = {{16{rhalf[15]}}, rhalf};
            MemLhu:  load_val = {16'b0, rhalf};
            MemLw:   load_val = rdata;
            default: load_val = '0;
        endcase
    end

    always_comb begin
        be    = '0;
        wdata = din_q;
        case (op_q)
            MemSb: begin
                be    = 4'b0001 << lane;
                wdata = {4{din_q[7:0]}};
            end
            MemSh: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din_q[15:0]}};
            end
            MemSw:   be = 4'b1111;
            default: be = '0;
        endcase
        we = (commit && !cur_mis) ? be : 4'b0000;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        mis_d   = mis_q;
        unique case (state_q)
            StIdle: begin
                if (req && is_access(rd_wr)) begin
                    op_d    = rd_wr;
                    addr_d  = addr[IdxBits+1:0];
                    din_d   = din;
                    ready_d = 1'b0;
                    state_d = StWait;
                    // Counter holds the number of edges still to go before RESP.
                    cnt_d   = is_misaligned(rd_wr, addr[1:0]) ? 4'd1 : 4'(Latency);
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    done_d  = 1'b1;
                    mis_d   = cur_mis;
                    dout_d  = (cur_mis || is_store(op_q)) ? '0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= MemNone;
            addr_q  <= '0;
            din_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            dout_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            mis_q   <= mis_d;
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign dout       = dout_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_dmem_ws.sv
// Bench for dmem_ws: byte-level reference model checked every cycle, directed
// literal vectors, randomized traffic with resets, and a Latency=4 reset-abort case.
`timescale 1ns/1ps
module tb_dmem_ws;
    import controls_pkg::*;

    localparam int unsigned Lat      = 2;
    localparam int unsigned MemBytes = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, ready, done, misaligned;
    mem_op       rd_wr;
    logic [31:0] addr, din, dout;
    logic        rst4, req4, ready4, done4, misaligned4;
    mem_op       rd_wr4;
    logic [31:0] addr4, din4, dout4;

    dmem_ws #(.Addr_bits(32), .Word_size(32), .Depth_words(256), .Latency(Lat)) u_dut (
        .clk(clk), .rst(rst), .req(req), .rd_wr(rd_wr), .addr(addr), .din(din),
        .ready(ready), .done(done), .dout(dout), .misaligned(misaligned)
    );

    dmem_ws #(.Addr_bits(32), .Word_size(32), .Depth_words(256), .Latency(4)) u_dut4 (
        .clk(clk), .rst(rst4), .req(req4), .rd_wr(rd_wr4), .addr(addr4), .din(din4),
        .ready(ready4), .done(done4), .dout(dout4), .misaligned(misaligned4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_bytes(mem_op op);
        case (op)
            MemLb, MemLbu, MemSb: return 1;
            MemLh, MemLhu, MemSh: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic bit is_acc(mem_op op);
        return op inside {MemLb, MemLh, MemLw, MemLbu, MemLhu, MemSb, MemSh, MemSw};
    endfunction

    function automatic bit is_st(mem_op op);
        return op inside {MemSb, MemSh, MemSw};
    endfunction

    // Reference model: byte array plus the edge number at which the response is due.
    logic [7:0]  mem_m [MemBytes];
    bit          model_on = 1'b0;
    bit          m_busy = 1'b0;
    int          m_resp = 0;
    int          edge_n = 0;
    mem_op       m_op = MemNone;
    logic [31:0] m_addr = '0, m_din = '0, m_dout = '0;
    logic        m_done = 1'b0, m_mis = 1'b0;

    task automatic model_complete();
        int          nb = op_bytes(m_op);
        int          a = int'(m_addr % MemBytes);
        logic [31:0] v = '0;
        logic [31:0] ones = '1;
        m_done = 1'b1;
        m_dout = '0;
        m_mis  = (m_addr % 32'(nb)) != 0;
        if (!m_mis) begin
            if (is_st(m_op)) begin
                for (int b = 0; b < nb; b++) mem_m[a + b] = m_din[8*b +: 8];
            end else begin
                for (int b = nb - 1; b >= 0; b--) v = {v[23:0], mem_m[a + b]};
                if ((m_op == MemLb || m_op == MemLh) && v[8*nb-1]) v = v | (ones << (8*nb));
                m_dout = v;
            end
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            model_on = 1'b1;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_dout   = '0;
            m_mis    = 1'b0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (req && is_acc(rd_wr)) begin
                m_busy = 1'b1;
                m_op   = rd_wr;
                m_addr = addr;
                m_din  = din;
                m_resp = edge_n + (((addr % 32'(op_bytes(rd_wr))) != 0) ? 1 : int'(Lat));
            end
        end else if (edge_n == m_resp) begin
            model_complete();
        end else if (edge_n == m_resp + 1) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end
        #1;
        if (model_on) begin
            check("ready", 32'(ready), 32'(!m_busy));
            check("done", 32'(done), 32'(m_done));
            check("dout", dout, m_dout);
            check("misaligned", 32'(misaligned), 32'(m_mis));
        end
    end

    // Issue one access on the Latency=2 instance; called at posedge+2.
    task automatic run_op(input mem_op op, input logic [31:0] a, input logic [31:0] d,
                          input bit chk, input logic [31:0] exp_d, input logic exp_m,
                          input int exp_lat);
        bit seen = 1'b0;
        int lat = 0;
        for (int i = 0; i < 20 && !ready; i++) begin
            @(posedge clk);
            #2;
        end
        req = 1'b1; rd_wr = op; addr = a; din = d;
        @(posedge clk);
        #2;
        req = 1'b0; rd_wr = MemNone;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                lat  = i;
                if (chk) begin
                    check($sformatf("%s@%0h dout", op.name(), a), dout, exp_d);
                    check($sformatf("%s@%0h misaligned", op.name(), a), 32'(misaligned),
                          32'(exp_m));
                end
            end
            #1;
        end
        check($sformatf("%s@%0h done seen", op.name(), a), 32'(seen), 32'd1);
        if (chk) check($sformatf("%s@%0h latency", op.name(), a), 32'(lat), 32'(exp_lat));
    endtask

    task automatic run4(input mem_op op, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d);
        bit seen = 1'b0;
        int lat = 0;
        for (int i = 0; i < 20 && !ready4; i++) begin
            @(posedge clk);
            #2;
        end
        req4 = 1'b1; rd_wr4 = op; addr4 = a; din4 = d;
        @(posedge clk);
        #2;
        req4 = 1'b0; rd_wr4 = MemNone;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done4) begin
                seen = 1'b1;
                lat  = i;
                check($sformatf("L4 %s@%0h dout", op.name(), a), dout4, exp_d);
            end
            #1;
        end
        check($sformatf("L4 %s@%0h done seen", op.name(), a), 32'(seen), 32'd1);
        check($sformatf("L4 %s@%0h latency", op.name(), a), 32'(lat), 32'd4);
    endtask

    function automatic mem_op rand_op();
        logic [3:0] v;
        if ($urandom % 5 == 0) v = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15));
        else v = 4'($urandom_range(1, 8));
        return mem_op'(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pulse4;
        rst = 1'b1; req = 1'b0; rd_wr = MemNone; addr = '0; din = '0;
        rst4 = 1'b1; req4 = 1'b0; rd_wr4 = MemNone; addr4 = '0; din4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset dout", dout, 32'd0);
        check("reset misaligned", 32'(misaligned), 32'd0);
        check("L4 reset ready", 32'(ready4), 32'd1);
        #1;
        rst = 1'b0; rst4 = 1'b0;

        for (int w = 0; w < 256; w++) run_op(MemSw, 32'(4 * w), $urandom(), 1'b0, '0, 1'b0, 0);

        run_op(MemSw,  32'd4,  32'h80FF_7F01, 1'b1, 32'h0, 1'b0, 2);
        run_op(MemSw,  32'd12, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 2);
        run_op(MemLb,  32'd4,  32'h0, 1'b1, 32'h0000_0001, 1'b0, 2);
        run_op(MemLb,  32'd5,  32'h0, 1'b1, 32'h0000_007F, 1'b0, 2);
        run_op(MemLbu, 32'd6,  32'h0, 1'b1, 32'h0000_00FF, 1'b0, 2);
        run_op(MemLb,  32'd6,  32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 2);
        run_op(MemLh,  32'd6,  32'h0, 1'b1, 32'hFFFF_80FF, 1'b0, 2);
        run_op(MemLhu, 32'd6,  32'h0, 1'b1, 32'h0000_80FF, 1'b0, 2);
        run_op(MemLw,  32'd4,  32'h0, 1'b1, 32'h80FF_7F01, 1'b0, 2);

        run_op(MemSw,  32'd8,  32'h1122_3344, 1'b1, 32'h0, 1'b0, 2);
        run_op(MemSb,  32'd9,  32'h0000_00AA, 1'b1, 32'h0, 1'b0, 2);
        run_op(MemSh,  32'd10, 32'h0000_BEEF, 1'b1, 32'h0, 1'b0, 2);
        run_op(MemLw,  32'd8,  32'h0, 1'b1, 32'hBEEF_AA44, 1'b0, 2);

        run_op(MemLw,  32'd2,  32'h0, 1'b1, 32'h0, 1'b1, 1);
        run_op(MemSh,  32'd3,  32'h0, 1'b1, 32'h0, 1'b1, 1);
        run_op(MemSw,  32'd13, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b1, 1);
        run_op(MemLw,  32'd12, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 2);

        run_op(MemSw,  32'h400, 32'h0000_0555, 1'b1, 32'h0, 1'b0, 2);
        run_op(MemLw,  32'h0,   32'h0, 1'b1, 32'h0000_0555, 1'b0, 2);

        // Back-to-back requests held high; the model decides which ones are taken.
        req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rd_wr = rand_op();
            addr  = $urandom % 2048;
            din   = $urandom;
            @(posedge clk);
            #2;
        end
        req = 1'b0; rd_wr = MemNone;

        for (int i = 0; i < 2500; i++) begin
            req   = ($urandom % 3) != 0;
            rd_wr = rand_op();
            addr  = ($urandom % 2 == 0) ? $urandom : ($urandom % 2048);
            din   = $urandom;
            rst   = ($urandom % 64) == 0;
            @(posedge clk);
            #2;
        end
        req = 1'b0; rd_wr = MemNone; rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;

        run4(MemSw, 32'd16, 32'h0102_0304, 32'h0);
        run4(MemLw, 32'd16, 32'h0, 32'h0102_0304);
        for (int i = 0; i < 20 && !ready4; i++) begin
            @(posedge clk);
            #2;
        end
        req4 = 1'b1; rd_wr4 = MemSw; addr4 = 32'd16; din4 = 32'hCAFE_F00D;
        @(posedge clk);
        #2;
        req4 = 1'b0; rd_wr4 = MemNone;
        @(posedge clk);
        #1;
        check("L4 busy before abort", 32'(ready4), 32'd0);
        #1;
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        check("L4 abort ready", 32'(ready4), 32'd1);
        check("L4 abort done", 32'(done4), 32'd0);
        check("L4 abort dout", dout4, 32'd0);
        #1;
        rst4 = 1'b0;
        pulse4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done4) pulse4 = 1'b1;
            #1;
        end
        check("L4 no done after abort", 32'(pulse4), 32'd0);
        run4(MemLw, 32'd16, 32'h0, 32'h0102_0304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
